// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan sequencer with a frame-synchronous shadow.
// Optional macro SEG_SCAN_LZB_EN: leading-zero blanking applied when the shadow loads.
module seg_scan_ctrl #(
  parameter int DWELL = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Hexs,
  input  logic [3:0]  point,
  input  logic [3:0]  LES,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [3:0]  Hexo,
  output logic        p,
  output logic        LE,
  output logic [3:0]  AN,
  output logic        frame_start
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam bit NOBLANK = (BLANK == 0);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    digit, digit_n;
  logic          boot;
  logic [15:0]   hex, hex_n;
  logic [3:0]    pt, pt_n;
  logic [3:0]    les, les_n;
  logic [3:0]    lzb;
  logic          bnd, load, enter;
  logic [3:0]    an_n, hexo_n;
  logic          p_n, le_n, fs_n;

`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    lzb    = 4'b0000;
    lzb[3] = (Hexs[15:12] == 4'h0);
    lzb[2] = (Hexs[15:8] == 8'h00);
    lzb[1] = (Hexs[15:4] == 12'h000);
  end
`else
  assign lzb = 4'b0000;
`endif

  // outputs entering S_SHOW see the shadow as loaded on this same edge
  assign load  = bnd & upd_req;
  assign hex_n = load ? Hexs : hex;
  assign pt_n  = load ? point : pt;
  assign les_n = load ? (LES | lzb) : les;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    digit_n = digit;
    bnd     = boot;
    enter   = 1'b0;
    unique case (state)
      S_BLANK: begin
        if (NOBLANK || cnt == BLAST) begin
          state_n = S_SHOW;
          cnt_n   = '0;
          enter   = 1'b1;
        end
      end
      S_SHOW: begin
        if (cnt == DLAST) begin
          cnt_n   = '0;
          digit_n = digit + 2'd1;
          enter   = NOBLANK;
          state_n = NOBLANK ? S_SHOW : S_BLANK;
          if (digit == 2'd3)
            bnd = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    an_n   = AN;
    hexo_n = Hexo;
    p_n    = p;
    le_n   = LE;
    fs_n   = 1'b0;
    if (enter) begin
      an_n   = ~(4'b0001 << digit_n);
      hexo_n = hex_n[{digit_n, 2'b00} +: 4];
      p_n    = pt_n[digit_n];
      le_n   = les_n[digit_n];
      fs_n   = (digit_n == 2'd0);
    end else if (state_n == S_BLANK) begin
      an_n = 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BLANK;
      cnt         <= '0;
      digit       <= 2'd0;
      boot        <= 1'b1;
      hex         <= 16'h0000;
      pt          <= 4'b0000;
      les         <= 4'b1111;
      AN          <= 4'b1111;
      Hexo        <= 4'h0;
      p           <= 1'b0;
      LE          <= 1'b1;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      digit       <= digit_n;
      boot        <= 1'b0;
      hex         <= hex_n;
      pt          <= pt_n;
      les         <= les_n;
      AN          <= an_n;
      Hexo        <= hexo_n;
      p           <= p_n;
      LE          <= le_n;
      upd_ack     <= load;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for two scan configs (4/2 and 3/0).
// Frame-position arithmetic model predicts digit starts and acks.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] Hexs;
  logic [3:0]  point, LES;
  logic        upd_req;

  logic       ack[2];
  logic [3:0] hexo[2];
  logic       pp[2];
  logic       le[2];
  logic [3:0] an[2];
  logic       fs[2];

  seg_scan_ctrl #(.DWELL(4), .BLANK(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .Hexs(Hexs), .point(point), .LES(LES),
    .upd_req(upd_req), .upd_ack(ack[0]), .Hexo(hexo[0]), .p(pp[0]),
    .LE(le[0]), .AN(an[0]), .frame_start(fs[0])
  );

  seg_scan_ctrl #(.DWELL(3), .BLANK(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .Hexs(Hexs), .point(point), .LES(LES),
    .upd_req(upd_req), .upd_ack(ack[1]), .Hexo(hexo[1]), .p(pp[1]),
    .LE(le[1]), .AN(an[1]), .frame_start(fs[1])
  );

  typedef struct packed {
    logic [31:0] t;
    logic [3:0]  an;
    logic [3:0]  hx;
    logic        p;
    logic        le;
    logic        fs;
  } sh_t;

  int n_chk, n_pass;
  int t;
  logic [15:0] mhex[2];
  logic [3:0]  mpt[2], mles[2];
  sh_t sq0[$], sq1[$];
  int  aq0[$], aq1[$];

  function automatic int dw(int k); return (k == 0) ? 4 : 3; endfunction
  function automatic int bl(int k); return (k == 0) ? 2 : 0; endfunction
  function automatic int ofs(int k); return (bl(k) == 0) ? 1 : bl(k); endfunction
  function automatic int per(int k); return 4 * (dw(k) + bl(k)); endfunction

  function automatic bit showing(int k, int tt);
    int s;
    if (tt < ofs(k)) return 1'b0;
    s = ((tt - ofs(k)) % per(k)) % (dw(k) + bl(k));
    return s < dw(k);
  endfunction

  function automatic logic [3:0] lzb_of(logic [15:0] h);
    logic [3:0] m;
    int top;
    m = 4'b0000;
    top = 0;
`ifdef SEG_SCAN_LZB_EN
    for (int i = 0; i < 4; i++)
      if (((h >> (4 * i)) & 16'h000F) != 16'h0000) top = i;
    for (int i = 1; i < 4; i++)
      if (i > top) m[i] = 1'b1;
`endif
    return m;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0d)", nm, act, exp, t);
  endtask

  task automatic fail(string nm);
    n_chk++;
    $display("FAIL %s: event missing or timed out (t=%0d)", nm, t);
  endtask

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < 2; k++) begin
      mhex[k] = 16'h0000;
      mpt[k]  = 4'h0;
      mles[k] = 4'hF;
    end
    sq0.delete(); sq1.delete();
    aq0.delete(); aq1.delete();
  endtask

  // reference model: one step per clock edge since reset release
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        t++;
        for (int k = 0; k < 2; k++) begin
          int r, d;
          bit bnd;
          sh_t e;
          bnd = (t == 1) || (t > ofs(k) &&
                (t - ofs(k)) % per(k) == (4 * dw(k) + 3 * bl(k)) % per(k));
          if (bnd && upd_req) begin
            mhex[k] = Hexs;
            mpt[k]  = point;
            mles[k] = LES | lzb_of(Hexs);
            if (k == 0) aq0.push_back(t);
            else aq1.push_back(t);
          end
          if (t >= ofs(k)) begin
            r = (t - ofs(k)) % per(k);
            if (r % (dw(k) + bl(k)) == 0) begin
              d = r / (dw(k) + bl(k));
              e.t  = t;
              e.an = 4'hF;
              e.an[d] = 1'b0;
              e.hx = mhex[k][4 * d +: 4];
              e.p  = mpt[k][d];
              e.le = mles[k][d];
              e.fs = (d == 0);
              if (k == 0) sq0.push_back(e);
              else sq1.push_back(e);
            end
          end
        end
      end
    end
  end

  // monitor
  logic [3:0] prev_an[2];
  initial begin
    prev_an[0] = 4'hF;
    prev_an[1] = 4'hF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_an[0] = 4'hF;
        prev_an[1] = 4'hF;
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit ev;
          sh_t e;
          int at;
          int sn, an_n;
          ev = (an[k] != 4'hF) && (an[k] != prev_an[k]);
          prev_an[k] = an[k];
          chk($sformatf("scan%0d", k),
              {62'd0, an[k] == 4'hF, ev ? 1'b0 : fs[k]},
              {62'd0, !showing(k, t), 1'b0});
          sn = (k == 0) ? sq0.size() : sq1.size();
          if (ev) begin
            if (sn == 0) begin
              fail($sformatf("show_extra%0d", k));
            end else begin
              e = (k == 0) ? sq0.pop_front() : sq1.pop_front();
              chk($sformatf("show%0d", k),
                  {37'd0, 16'(t), an[k], hexo[k], pp[k], le[k], fs[k]},
                  {37'd0, e.t[15:0], e.an, e.hx, e.p, e.le, e.fs});
            end
          end else if (sn > 0) begin
            e = (k == 0) ? sq0[0] : sq1[0];
            if (int'(e.t) <= t) begin
              fail($sformatf("show_miss%0d", k));
              if (k == 0) void'(sq0.pop_front());
              else void'(sq1.pop_front());
            end
          end
          an_n = (k == 0) ? aq0.size() : aq1.size();
          if (ack[k]) begin
            if (an_n == 0) begin
              fail($sformatf("ack_extra%0d", k));
            end else begin
              at = (k == 0) ? aq0.pop_front() : aq1.pop_front();
              chk($sformatf("ack%0d", k), 64'(t), 64'(at));
            end
          end else if (an_n > 0) begin
            at = (k == 0) ? aq0[0] : aq1[0];
            if (at <= t) begin
              fail($sformatf("ack_miss%0d", k));
              if (k == 0) void'(aq0.pop_front());
              else void'(aq1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack();
    bit g0, g1;
    g0 = 1'b0;
    g1 = 1'b0;
    for (int i = 0; i < 200 && !(g0 && g1); i++) begin
      @(negedge clk);
      if (ack[0]) g0 = 1'b1;
      if (ack[1]) g1 = 1'b1;
    end
    if (!(g0 && g1)) fail("ack_wait");
  endtask

  task automatic wait_an(int k, logic [3:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (an[k] == v) hit = 1'b1;
    end
    if (!hit) fail("an_wait");
  endtask

  task automatic rst_chk(string nm);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s%0d", nm, k),
          {48'd0, an[k], hexo[k], pp[k], le[k], ack[k], fs[k]},
          {48'd0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    Hexs    = 16'hFFFF;
    point   = 4'h0;
    LES     = 4'h0;
    upd_req = 1'b0;
    #12;
    rst_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(48);

    Hexs = 16'hA5C3; point = 4'b0100; LES = 4'b0000; upd_req = 1'b1;
    wait_ack();
    upd_req = 1'b0;
    wait_an(0, 4'b1101);
    Hexs = 16'h1234;
    cyc(60);

    Hexs = 16'h0042; LES = 4'b0000; upd_req = 1'b1;
    wait_ack();
    upd_req = 1'b0;
    cyc(50);
    Hexs = 16'h0000; upd_req = 1'b1;
    wait_ack();
    upd_req = 1'b0;
    cyc(50);

    repeat (40) begin
      Hexs    = 16'($urandom);
      point   = 4'($urandom);
      LES     = 4'($urandom);
      upd_req = 1'($urandom);
      cyc($urandom_range(1, 30));
    end
    upd_req = 1'b0;

    Hexs = 16'hBEEF; point = 4'hF; LES = 4'h0; upd_req = 1'b1;
    wait_ack();
    upd_req = 1'b0;
    wait_an(0, 4'b1011);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    rst_chk("async_rst");
    cyc(2);
    rst_n = 1'b1;
    cyc(60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
